// File: rtl/trace_capture_mc.sv
// Multi-channel triggered sensor trace recorder: pre-trigger ring buffer per channel,
// decimated capture with end-of-operation marker, byte-serial dump over the uart_tx handshake.
module trace_capture_mc #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int PRETRIG  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
    input  logic                         arm_i,
    input  logic                         trig_i,
    input  logic                         mark_i,
    input  logic [3:0]                   decim_i,
    input  logic                         dump_i,
    output logic [7:0]                   tx_byte_o,
    output logic                         tx_dv_o,
    input  logic                         tx_done_i,
    output logic                         busy_o,
    output logic                         ready_o,
    output logic                         overflow_o
);

    localparam int CNT_W = ADDR_W + 3;
    localparam logic [SAMPLE_W-1:0] MAX   = '1;
    localparam logic [SAMPLE_W-1:0] MAXM1 = {{(SAMPLE_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0]   PRE_A  = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W:0]     PRE_L  = (ADDR_W+1)'(PRETRIG);
    localparam logic [ADDR_W:0]     POST_L = (ADDR_W+1)'(DEPTH - PRETRIG);
    localparam logic [ADDR_W:0]     PONE   = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0]    TOTAL  = CNT_W'(3 + CHANNELS*DEPTH);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, READY, SEND, WAIT} state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W:0]        filled;
    logic [ADDR_W:0]        post;
    logic [3:0]             dcnt;
    logic [3:0]             decim_r;
    logic [CNT_W-1:0]       bcnt;
    logic [CNT_W-1:0]       k;
    logic [ADDR_W-1:0]      rd_addr;
    logic [CHANNELS*8-1:0]  rd_bytes;
    logic [7:0]             data_byte;
    logic [7:0]             next_byte;
    logic                   capturing;
    logic                   store;

    assign capturing = (state == ARMED) || (state == CAPTURE);
    assign store     = capturing && (dcnt == 4'd0);
    assign busy_o    = (state != IDLE) && (state != READY);

    // bcnt always names the next byte to send, so the RAM read is already
    // settled by the time SEND latches it into tx_byte_o
    assign k       = bcnt - CNT_W'(3);
    assign rd_addr = base + k[ADDR_W-1:0];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLE_W-1:0] mem [DEPTH];
        logic [SAMPLE_W-1:0] s;
        logic [SAMPLE_W-1:0] wdata;
        logic [SAMPLE_W-1:0] rd_q;

        assign s     = sample_i[c*SAMPLE_W +: SAMPLE_W];
        assign wdata = mark_i ? MAX : ((s == MAX) ? MAXM1 : s);

        always_ff @(posedge clk) begin
            if (store)
                mem[wr_ptr] <= wdata;
            rd_q <= mem[rd_addr];
        end

        assign rd_bytes[c*8 +: 8] = 8'(rd_q);
    end

    always_comb begin
        data_byte = 8'h00;
        for (int c = 0; c < CHANNELS; c++)
            if (k[CNT_W-1:ADDR_W] == 3'(c))
                data_byte = rd_bytes[c*8 +: 8];
    end

    always_comb begin
        if (bcnt == CNT_W'(0))
            next_byte = 8'hA5;
        else if (bcnt == CNT_W'(1))
            next_byte = 8'(CHANNELS);
        else if (bcnt == CNT_W'(2))
            next_byte = {4'b0000, decim_r};
        else
            next_byte = data_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            base       <= '0;
            filled     <= '0;
            post       <= '0;
            dcnt       <= '0;
            decim_r    <= '0;
            bcnt       <= '0;
            tx_byte_o  <= '0;
            tx_dv_o    <= 1'b0;
            ready_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            tx_dv_o <= 1'b0;
            if (capturing)
                dcnt <= (dcnt == decim_r) ? 4'd0 : dcnt + 4'd1;

            if (arm_i && state != SEND && state != WAIT) begin
                state      <= ARMED;
                wr_ptr     <= '0;
                filled     <= '0;
                dcnt       <= '0;
                decim_r    <= decim_i;
                overflow_o <= 1'b0;
                ready_o    <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (store) begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            if (filled != PRE_L)
                                filled <= filled + PONE;
                        end
                        // the trigger-cycle store is the first post sample
                        if (trig_i && filled == PRE_L) begin
                            base <= wr_ptr - PRE_A;
                            post <= POST_L - (ADDR_W+1)'(store);
                            if (store && POST_L == PONE) begin
                                state   <= READY;
                                ready_o <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (store) begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            post   <= post - PONE;
                            if (post == PONE) begin
                                state   <= READY;
                                ready_o <= 1'b1;
                            end
                        end
                        if (trig_i)
                            overflow_o <= 1'b1;
                    end
                    READY: begin
                        if (dump_i) begin
                            state <= SEND;
                            bcnt  <= '0;
                        end
                    end
                    SEND: begin
                        tx_byte_o <= next_byte;
                        tx_dv_o   <= 1'b1;
                        bcnt      <= bcnt + CNT_W'(1);
                        state     <= WAIT;
                    end
                    WAIT: begin
                        if (tx_done_i) begin
                            if (bcnt == TOTAL) begin
                                state   <= IDLE;
                                ready_o <= 1'b0;
                            end else begin
                                state <= SEND;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_mc.sv
// Randomised and directed bench for trace_capture_mc, checked against an array-based
// model of the stored trace (store cycles, trigger point, window extraction).
module tb_trace_capture_mc;

    localparam int CH    = 2;
    localparam int SW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PRE   = 4;
    localparam int POST  = DEPTH - PRE;
    localparam int PLAN  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH*SW-1:0] sample_i;
    logic          arm_i, trig_i, mark_i, dump_i, tx_done_i;
    logic [3:0]    decim_i;
    logic [7:0]    tx_byte_o;
    logic          tx_dv_o, busy_o, ready_o, overflow_o;

    trace_capture_mc #(
        .CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .PRETRIG(PRE)
    ) dut (
        .clk(clk), .rst(rst), .sample_i(sample_i), .arm_i(arm_i), .trig_i(trig_i),
        .mark_i(mark_i), .decim_i(decim_i), .dump_i(dump_i), .tx_byte_o(tx_byte_o),
        .tx_dv_o(tx_dv_o), .tx_done_i(tx_done_i), .busy_o(busy_o), .ready_o(ready_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int p_s0 [PLAN];
    int p_s1 [PLAN];
    bit p_m  [PLAN];
    bit p_t  [PLAN];
    int exp_tr [CH][DEPTH];
    int ready_cyc;
    bit exp_ovf;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip(input int s, input bit m);
        if (m) return 255;
        return (s > 254) ? 254 : s;
    endfunction

    task automatic clearPlan();
        for (int t = 0; t < PLAN; t++) begin
            p_s0[t] = 0; p_s1[t] = 0; p_m[t] = 0; p_t[t] = 0;
        end
    endtask

    task automatic rampPlan();
        for (int t = 0; t < PLAN; t++) begin
            p_s0[t] = t % 256;
            p_s1[t] = (100 + t) % 256;
        end
    endtask

    // stores happen every d+1 cycles from the first armed cycle; the trace is the
    // DEPTH stores starting PRE before the first store at or after the accepted trigger
    task automatic runModel(input int d);
        int st0[$];
        int st1[$];
        int p;
        p = -1;
        ready_cyc = -1;
        exp_ovf = 0;
        for (int t = 0; t < PLAN; t++) begin
            if (p < 0) begin
                if (p_t[t] && st0.size() >= PRE) p = st0.size();
            end else if (p_t[t]) begin
                exp_ovf = 1;
            end
            if (t % (d + 1) == 0) begin
                st0.push_back(clip(p_s0[t], p_m[t]));
                st1.push_back(clip(p_s1[t], p_m[t]));
            end
            if (p >= 0 && st0.size() == p + POST) begin
                ready_cyc = t;
                break;
            end
        end
        if (p >= 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_tr[0][i] = st0[p - PRE + i];
                exp_tr[1][i] = st1[p - PRE + i];
            end
        end
    endtask

    task automatic applyStimulus(input int d, input bit trig_on_arm);
        runModel(d);
        arm_i = 1; trig_i = trig_on_arm; decim_i = 4'(d);
        tick();
        arm_i = 0; trig_i = 0;
        checkOutput("busy_after_arm", busy_o, 1);
        checkOutput("ovf_clear_on_arm", overflow_o, 0);
        for (int t = 0; t <= ready_cyc; t++) begin
            sample_i = {8'(p_s1[t]), 8'(p_s0[t])};
            mark_i   = p_m[t];
            trig_i   = p_t[t];
            tick();
            if (t == ready_cyc - 1) checkOutput("ready_not_early", ready_o, 0);
        end
        mark_i = 0; trig_i = 0;
        checkOutput("ready_after_capture", ready_o, 1);
        checkOutput("busy_in_ready", busy_o, 0);
        checkOutput("overflow", overflow_o, 32'(exp_ovf));
    endtask

    // uart_tx stand-in: tx_done_i pulses 5 cycles after each observed strobe
    task automatic dumpCheck(input int d, input int abort_at);
        int exp_b[$];
        int got[$];
        int due;
        exp_b.push_back(8'hA5);
        exp_b.push_back(CH);
        exp_b.push_back(d);
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < DEPTH; i++) exp_b.push_back(exp_tr[c][i]);
        due = -1;
        dump_i = 1;
        tick();
        dump_i = 0;
        for (int j = 0; j < 600; j++) begin
            tx_done_i = (j == due);
            tick();
            if (tx_dv_o) begin
                got.push_back(int'(tx_byte_o));
                due = j + 5;
                if (got.size() == abort_at) break;
            end
            if (!busy_o) break;
        end
        tx_done_i = 0;
        if (abort_at > 0) begin
            for (int i = 0; i < got.size(); i++) checkOutput("abort_byte", got[i], exp_b[i]);
            return;
        end
        checkOutput("dump_byte_count", got.size(), exp_b.size());
        for (int i = 0; i < got.size() && i < exp_b.size(); i++)
            checkOutput($sformatf("dump_byte_%0d", i), got[i], exp_b[i]);
        checkOutput("ready_after_dump", ready_o, 0);
        checkOutput("busy_after_dump", busy_o, 0);
    endtask

    initial begin
        int dvs;
        int d;
        int t1;
        int t2;
        rst = 1; arm_i = 0; trig_i = 0; mark_i = 0; dump_i = 0; tx_done_i = 0;
        decim_i = 0; sample_i = '0;
        tick(); tick();
        checkOutput("rst_tx_byte", tx_byte_o, 0);
        checkOutput("rst_tx_dv", tx_dv_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_ready", ready_o, 0);
        checkOutput("rst_overflow", overflow_o, 0);
        rst = 0;
        tick();

        $display("[TB] ramp capture, trigger at sample 10");
        clearPlan(); rampPlan(); p_t[10] = 1;
        applyStimulus(0, 0);
        checkOutput("t1_ready_cycle", ready_cyc, 21);
        dumpCheck(0, 0);

        $display("[TB] saturated input with marker");
        clearPlan();
        for (int t = 0; t < PLAN; t++) begin p_s0[t] = 255; p_s1[t] = 255; end
        p_t[6] = 1; p_m[8] = 1;
        applyStimulus(0, 0);
        dumpCheck(0, 0);

        $display("[TB] decimation by 3");
        clearPlan(); rampPlan(); p_t[20] = 1;
        applyStimulus(2, 0);
        dumpCheck(2, 0);

        $display("[TB] early trigger ignored, late trigger overflows");
        clearPlan(); rampPlan(); p_t[1] = 1; p_t[9] = 1; p_t[13] = 1;
        applyStimulus(0, 0);
        checkOutput("t5_overflow_seen", overflow_o, 1);
        dumpCheck(0, 0);

        for (int r = 0; r < 4; r++) begin
            $display("[TB] random capture %0d", r);
            clearPlan();
            d = $urandom_range(0, 3);
            for (int t = 0; t < PLAN; t++) begin
                p_s0[t] = $urandom_range(0, 255);
                p_s1[t] = $urandom_range(0, 255);
                p_m[t]  = ($urandom_range(0, 15) == 0);
            end
            t1 = $urandom_range(0, 5);
            t2 = $urandom_range(12, 40);
            p_t[t1] = 1; p_t[t2] = 1;
            if ($urandom_range(0, 1) == 1) p_t[t2 + $urandom_range(1, 10)] = 1;
            applyStimulus(d, 0);
            dumpCheck(d, 0);
        end

        $display("[TB] reset during dump");
        clearPlan(); rampPlan(); p_t[10] = 1;
        applyStimulus(0, 0);
        dumpCheck(0, 7);
        rst = 1;
        tick();
        rst = 0;
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_ready", ready_o, 0);
        checkOutput("abort_tx_dv", tx_dv_o, 0);
        dvs = 0;
        for (int j = 0; j < 60; j++) begin
            tx_done_i = (j % 5 == 4);
            tick();
            if (tx_dv_o) dvs++;
        end
        tx_done_i = 0;
        checkOutput("no_dv_after_reset", dvs, 0);

        $display("[TB] arm and trigger in the same cycle");
        clearPlan(); rampPlan(); p_t[12] = 1;
        applyStimulus(0, 1);
        dumpCheck(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_capture_mc.md
Name: trace_capture_mc

Overview:
- Multi-channel, triggered on-chip sensor trace recorder; successor to the single-channel TDC sample buffer.
- Records decoded TDC/RO sensor samples around an AES encryption, with pre-trigger history, programmable decimation and an end-of-operation marker.
- Dumps the trace byte-serially through the existing uart_tx handshake.
- Sits between the tdc_decode instances and the top-level main FSM.

Parameters:
CHANNELS, 2, number of sensor channels captured in parallel (1..4)
SAMPLE_W, 8, bits per decoded sample (1..8); zero-extended to a byte on output
DEPTH, 1024, samples stored per channel (power of 2)
ADDR_W, 10, log2(DEPTH)
PRETRIG, 16, samples kept from before the trigger (0..DEPTH-1)

Ports:
clk  in  1  sensor sample clock (clk0 domain)
rst  in  1  synchronous, active-high reset
sample_i  in  CHANNELS*SAMPLE_W  decoded sensor values; channel k at [k*SAMPLE_W +: SAMPLE_W]
arm_i  in  1  1-cycle pulse: start a new capture
trig_i  in  1  level/pulse: AES start (Drdy), synchronised by caller
mark_i  in  1  AES done (Dvld); marks the sample
decim_i  in  4  store one sample every decim_i+1 cycles
dump_i  in  1  1-cycle pulse: start readout
tx_byte_o  out  8  byte to uart_tx
tx_dv_o  out  1  1-cycle send strobe
tx_done_i  in  1  uart_tx completion pulse
busy_o  out  1  high in any state except IDLE and READY
ready_o  out  1  trace complete and not yet dumped
overflow_o  out  1  sticky: trig_i seen while capturing; cleared on arm_i

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; write pointer, counters and decimation counter 0. Memory contents are not reset. rst mid-capture or mid-dump aborts immediately to IDLE with no further tx_dv_o.
- Sample path: MAX = 2^SAMPLE_W-1. Stored value = MAX when mark_i=1 on the store cycle; otherwise min(sample, MAX-1), so MAX is a unique marker.
- Decimation: counter dcnt runs 0..decim_i in ARMED/CAPTURE. A store occurs when dcnt==0. decim_i is sampled on arm_i. decim_i=0 stores every cycle.
- States:
  - IDLE: arm_i -> ARMED. wr_ptr=0, filled=0, overflow_o=0.
  - ARMED: store to mem[wr_ptr] on each store cycle; wr_ptr wraps mod DEPTH; filled saturates at PRETRIG.
    - trig_i is ignored while filled<PRETRIG.
    - Otherwise trig_i -> CAPTURE; base = wr_ptr - PRETRIG (mod DEPTH); post = DEPTH-PRETRIG.
    - The sample on the trigger cycle counts as the first post sample if it is a store cycle.
  - CAPTURE: store and decrement post on each store cycle. The store that makes post==0 -> READY, ready_o=1 on the next cycle.
    - trig_i here sets overflow_o and has no other effect.
    - arm_i here restarts at ARMED.
  - READY: dump_i -> SEND with idx=0, ch=0, header phase. arm_i -> ARMED and discards the trace.
  - SEND: assert tx_dv_o for exactly 1 cycle with tx_byte_o valid, then WAIT.
  - WAIT: hold tx_byte_o stable; on tx_done_i advance and return to SEND. After the last byte -> IDLE, ready_o=0.
- Dump byte order:
  - 0xA5
  - CHANNELS
  - decim_i (zero-extended)
  - per channel 0..CHANNELS-1: DEPTH bytes from mem[(base+i) mod DEPTH], i=0..DEPTH-1
  - Total = 3 + CHANNELS*DEPTH bytes.
- Memory: one inferred RAM per channel. Write port in ARMED/CAPTURE; read port registered with 1-cycle latency. SEND must account for that latency so tx_byte_o is correct when tx_dv_o=1.
- Simultaneous events:
  - arm_i wins over trig_i/dump_i in the same cycle.
  - mark_i and trig_i together: the sample is stored as MAX.
  - tx_done_i outside WAIT is ignored.
- Throughput: at most one byte per tx_done_i; no dropped or duplicated bytes.

Test Plan:
1. Bench parameters CHANNELS=2, DEPTH=16, PRETRIG=4, decim_i=0. Ramp ch0=n, ch1=100+n; arm, trig at n=10 -> ch0 trace 6..21, ch1 106..121, ready_o after 12 post stores.
2. Dump of test 1 with a uart_tx model (tx_done_i 5 cycles after tx_dv_o) -> exactly 35 bytes: A5,02,00, then 6..21, then 106..121; one tx_dv_o per byte.
3. Ch0 input 255 (SAMPLE_W=8); mark_i on post sample 3 -> that entry stored as FF in both channels; all unmarked entries stored as FE.
4. decim_i=2 with ramp input -> stored ch0 values step by 3; trace spans 48 cycles.
5. trig_i two cycles after arm_i (filled<4) -> ignored, stays ARMED. Later trig_i -> capture; second trig_i during CAPTURE -> overflow_o=1.
6. rst asserted mid-dump after byte 7 -> next cycle busy_o=0, ready_o=0, tx_dv_o never re-asserted. arm_i plus trig_i in the same cycle -> ARMED only.
